// File: rtl/arm_pipelined_mem_arbiter_if.sv
// Bundle of fetch, data, memory-side and hazard-unit signals around the memory arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory side.
interface arm_pipelined_mem_arbiter_if #(
  parameter int unsigned BusWidth = 32
);
  logic                i_Instr_Req;
  logic [BusWidth-1:0] i_Instr_Addr;
  logic [BusWidth-1:0] o_Instr_Data;
  logic                o_Instr_Valid;
  logic                i_Data_Req;
  logic                i_Data_Write;
  logic [BusWidth-1:0] i_Data_Addr;
  logic [BusWidth-1:0] i_Data_WData;
  logic [BusWidth-1:0] o_Data_RData;
  logic                o_Data_Valid;
  logic                o_Mem_Req;
  logic                o_Mem_Write;
  logic [BusWidth-1:0] o_Mem_Addr;
  logic [BusWidth-1:0] o_Mem_WData;
  logic                i_Mem_Ack;
  logic [BusWidth-1:0] i_Mem_RData;
  logic                o_Stall_Fetch;
  logic                o_Stall_Memory;
  logic                o_Bus_Error;

  modport slave (
    input  i_Instr_Req, i_Instr_Addr, i_Data_Req, i_Data_Write, i_Data_Addr, i_Data_WData,
           i_Mem_Ack, i_Mem_RData,
    output o_Instr_Data, o_Instr_Valid, o_Data_RData, o_Data_Valid, o_Mem_Req, o_Mem_Write,
           o_Mem_Addr, o_Mem_WData, o_Stall_Fetch, o_Stall_Memory, o_Bus_Error
  );

  modport master (
    output i_Instr_Req, i_Instr_Addr, i_Data_Req, i_Data_Write, i_Data_Addr, i_Data_WData,
           i_Mem_Ack, i_Mem_RData,
    input  o_Instr_Data, o_Instr_Valid, o_Data_RData, o_Data_Valid, o_Mem_Req, o_Mem_Write,
           o_Mem_Addr, o_Mem_WData, o_Stall_Fetch, o_Stall_Memory, o_Bus_Error
  );
endinterface

// File: rtl/arm_pipelined_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and data stages,
// with per-access timeout abort and a sticky bus error.
module arm_pipelined_mem_arbiter #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input logic                        i_CLK,
  input logic                        i_RESET,
  arm_pipelined_mem_arbiter_if.slave bus
);
  localparam int unsigned     CntW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StInstr, StData} state_e;

  state_e              r_state, w_state;
  logic [CntW-1:0]     r_cnt, w_cnt;
  logic                r_last_data, w_last_data;
  logic                r_mem_req, w_mem_req;
  logic                r_mem_write, w_mem_write;
  logic [BusWidth-1:0] r_mem_addr, w_mem_addr;
  logic [BusWidth-1:0] r_mem_wdata, w_mem_wdata;
  logic                r_instr_valid, w_instr_valid;
  logic [BusWidth-1:0] r_instr_data, w_instr_data;
  logic                r_data_valid, w_data_valid;
  logic [BusWidth-1:0] r_data_rdata, w_data_rdata;
  logic                r_bus_error, w_bus_error;
  logic                w_instr_elig, w_data_elig;

  // A side whose Valid is high this cycle is masked so it can present its next request.
  assign w_instr_elig = bus.i_Instr_Req & ~r_instr_valid;
  assign w_data_elig  = bus.i_Data_Req & ~r_data_valid;

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_last_data   <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_instr_valid <= 1'b0;
      r_instr_data  <= '0;
      r_data_valid  <= 1'b0;
      r_data_rdata  <= '0;
      r_bus_error   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_last_data   <= w_last_data;
      r_mem_req     <= w_mem_req;
      r_mem_write   <= w_mem_write;
      r_mem_addr    <= w_mem_addr;
      r_mem_wdata   <= w_mem_wdata;
      r_instr_valid <= w_instr_valid;
      r_instr_data  <= w_instr_data;
      r_data_valid  <= w_data_valid;
      r_data_rdata  <= w_data_rdata;
      r_bus_error   <= w_bus_error;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_last_data   = r_last_data;
    w_mem_req     = r_mem_req;
    w_mem_write   = r_mem_write;
    w_mem_addr    = r_mem_addr;
    w_mem_wdata   = r_mem_wdata;
    w_instr_valid = 1'b0;
    w_instr_data  = r_instr_data;
    w_data_valid  = 1'b0;
    w_data_rdata  = r_data_rdata;
    w_bus_error   = r_bus_error;

    case (r_state)
      StIdle: begin
        // On conflict, grant whichever side was not served last.
        if (w_data_elig && (!w_instr_elig || !r_last_data)) begin
          w_state     = StData;
          w_cnt       = '0;
          w_mem_req   = 1'b1;
          w_mem_write = bus.i_Data_Write;
          w_mem_addr  = bus.i_Data_Addr;
          w_mem_wdata = bus.i_Data_WData;
        end else if (w_instr_elig) begin
          w_state     = StInstr;
          w_cnt       = '0;
          w_mem_req   = 1'b1;
          w_mem_write = 1'b0;
          w_mem_addr  = bus.i_Instr_Addr;
          w_mem_wdata = '0;
        end
      end
      StInstr, StData: begin
        if (bus.i_Mem_Ack || (r_cnt == CntLast)) begin
          w_state     = StIdle;
          w_mem_req   = 1'b0;
          w_mem_write = 1'b0;
          if (r_state == StInstr) begin
            w_instr_valid = 1'b1;
            w_instr_data  = bus.i_Mem_Ack ? bus.i_Mem_RData : '0;
          end else begin
            w_data_valid = 1'b1;
            w_data_rdata = (bus.i_Mem_Ack && !r_mem_write) ? bus.i_Mem_RData : '0;
          end
          if (bus.i_Mem_Ack) begin
            w_last_data = (r_state == StData);
          end else begin
            w_bus_error = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  assign bus.o_Mem_Req      = r_mem_req;
  assign bus.o_Mem_Write    = r_mem_write;
  assign bus.o_Mem_Addr     = r_mem_addr;
  assign bus.o_Mem_WData    = r_mem_wdata;
  assign bus.o_Instr_Valid  = r_instr_valid;
  assign bus.o_Instr_Data   = r_instr_data;
  assign bus.o_Data_Valid   = r_data_valid;
  assign bus.o_Data_RData   = r_data_rdata;
  assign bus.o_Bus_Error    = r_bus_error;
  assign bus.o_Stall_Fetch  = bus.i_Instr_Req & ~r_instr_valid;
  assign bus.o_Stall_Memory = bus.i_Data_Req & ~r_data_valid;
endmodule

// File: tb/tb_arm_pipelined_mem_arbiter.sv
// Cycle-by-cycle vector bench for arm_pipelined_mem_arbiter (TimeoutCycles = 4), plus a
// hand-written timeout sequence with a bounded wait.
module tb_arm_pipelined_mem_arbiter;
  localparam int unsigned Tmo = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  arm_pipelined_mem_arbiter_if #(.BusWidth(32)) bus ();

  arm_pipelined_mem_arbiter #(
    .BusWidth     (32),
    .TimeoutCycles(Tmo)
  ) u_dut (
    .i_CLK  (clk),
    .i_RESET(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq;
    logic [31:0] iaddr;
    logic        dreq, dwr;
    logic [31:0] daddr, dwd;
    logic        ack;
    logic [31:0] rdata;
    logic        e_mreq, e_mwr;
    logic [31:0] e_maddr, e_mwd;
    logic        e_iv;
    logic [31:0] e_id;
    logic        e_dv;
    logic [31:0] e_dd;
    logic        e_sf, e_sm, e_be;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a_rst, a_ireq, input logic [31:0] a_iaddr,
                     input logic a_dreq, a_dwr, input logic [31:0] a_daddr, a_dwd,
                     input logic a_ack, input logic [31:0] a_rdata,
                     input logic x_mreq, x_mwr, input logic [31:0] x_maddr, x_mwd,
                     input logic x_iv, input logic [31:0] x_id,
                     input logic x_dv, input logic [31:0] x_dd,
                     input logic x_sf, x_sm, x_be);
    vec_t v;
    v.rst = a_rst; v.ireq = a_ireq; v.iaddr = a_iaddr; v.dreq = a_dreq; v.dwr = a_dwr;
    v.daddr = a_daddr; v.dwd = a_dwd; v.ack = a_ack; v.rdata = a_rdata;
    v.e_mreq = x_mreq; v.e_mwr = x_mwr; v.e_maddr = x_maddr; v.e_mwd = x_mwd;
    v.e_iv = x_iv; v.e_id = x_id; v.e_dv = x_dv; v.e_dd = x_dd;
    v.e_sf = x_sf; v.e_sm = x_sm; v.e_be = x_be;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.i_Instr_Req  = v.ireq;
    bus.i_Instr_Addr = v.iaddr;
    bus.i_Data_Req   = v.dreq;
    bus.i_Data_Write = v.dwr;
    bus.i_Data_Addr  = v.daddr;
    bus.i_Data_WData = v.dwd;
    bus.i_Mem_Ack    = v.ack;
    bus.i_Mem_RData  = v.rdata;
  endtask

  initial begin
    logic ok;
    int   seen;
    int   mcnt;
    logic [31:0] vdata;
    logic berr;
    vec_t idle;

    errors = 0;
    checks = 0;
    idle = '{default: '0};
    drive(idle);
    rst = 1'b1;

    // Columns: rst ireq iaddr | dreq dwr daddr dwd | ack rdata ||
    //          mreq mwr maddr mwd | iv id | dv dd | sf sm be   (one row per clock cycle)
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);           // reset state
    // Fetch only, ack in first Mem_Req cycle
    add(0,1,'h100, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h100, 0,0,0,0, 1,'hE3A01005, 1,0,'h100,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h100, 0,0,0,0, 0,0, 0,0,0,0, 1,'hE3A01005, 0,0, 0,0,0);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);
    // Conflict: data wins, fetch granted in the Data_Valid cycle
    add(0,1,'h104, 1,0,'h200,0, 0,0, 0,0,0,0, 0,0, 0,0, 1,1,0);
    add(0,1,'h104, 1,0,'h200,0, 1,'h11111111, 1,0,'h200,0, 0,0, 0,0, 1,1,0);
    add(0,1,'h104, 1,0,'h200,0, 0,0, 0,0,0,0, 0,0, 1,'h11111111, 1,0,0);
    add(0,1,'h104, 0,0,0,0, 0,0, 1,0,'h104,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h104, 0,0,0,0, 1,'h22222222, 1,0,'h104,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h104, 0,0,0,0, 0,0, 0,0,0,0, 1,'h22222222, 0,0, 0,0,0);
    // Data-only access, then a conflict goes to fetch
    add(0,0,0, 1,0,'h204,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,0,'h204,0, 1,'h33333333, 1,0,'h204,0, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,0,'h204,0, 0,0, 0,0,0,0, 0,0, 1,'h33333333, 0,0,0);
    add(0,1,'h108, 1,0,'h208,0, 0,0, 0,0,0,0, 0,0, 0,0, 1,1,0);
    add(0,1,'h108, 1,0,'h208,0, 1,'h44444444, 1,0,'h108,0, 0,0, 0,0, 1,1,0);
    add(0,1,'h108, 1,0,'h208,0, 0,0, 0,0,0,0, 1,'h44444444, 0,0, 0,1,0);
    add(0,0,0, 1,0,'h208,0, 1,'h55555555, 1,0,'h208,0, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,0,'h208,0, 0,0, 0,0,0,0, 0,0, 1,'h55555555, 0,0,0);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);
    // Store held 3 cycles, read data forced to 0
    add(0,0,0, 1,1,'h300,'hDEADBEEF, 0,0, 0,0,0,0, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,1,'h300,'hDEADBEEF, 0,'hAAAAAAAA, 1,1,'h300,'hDEADBEEF, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,1,'h300,'hDEADBEEF, 0,'hAAAAAAAA, 1,1,'h300,'hDEADBEEF, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,1,'h300,'hDEADBEEF, 1,'hAAAAAAAA, 1,1,'h300,'hDEADBEEF, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,1,'h300,'hDEADBEEF, 0,0, 0,0,0,0, 0,0, 1,0, 0,0,0);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);
    // Fetch timeout: Mem_Req for 4 cycles, abort Valid with 0, sticky bus error
    add(0,1,'h10C, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h10C, 0,0,0,0, 0,0, 1,0,'h10C,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h10C, 0,0,0,0, 0,0, 1,0,'h10C,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h10C, 0,0,0,0, 0,0, 1,0,'h10C,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h10C, 0,0,0,0, 0,0, 1,0,'h10C,0, 0,0, 0,0, 1,0,0);
    add(0,1,'h10C, 0,0,0,0, 0,0, 0,0,0,0, 1,0, 0,0, 0,0,1);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,1);
    add(0,1,'h110, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 1,0,1);
    add(0,1,'h110, 0,0,0,0, 1,'h12345678, 1,0,'h110,0, 0,0, 0,0, 1,0,1);
    add(0,1,'h110, 0,0,0,0, 0,0, 0,0,0,0, 1,'h12345678, 0,0, 0,0,1);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,1);
    // Reset on second cycle of an in-flight load drops it silently
    add(0,0,0, 1,0,'h400,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,1,1);
    add(0,0,0, 1,0,'h400,0, 0,0, 1,0,'h400,0, 0,0, 0,0, 0,1,1);
    add(1,0,0, 1,0,'h400,0, 0,0, 1,0,'h400,0, 0,0, 0,0, 0,1,1);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);
    add(0,0,0, 1,0,'h400,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,0,'h400,0, 1,'h0BADF00D, 1,0,'h400,0, 0,0, 0,0, 0,1,0);
    add(0,0,0, 1,0,'h400,0, 0,0, 0,0,0,0, 0,0, 1,'h0BADF00D, 0,0,0);
    add(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);

    repeat (3) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      ok = (bus.o_Mem_Req === vecs[i].e_mreq) && (bus.o_Instr_Valid === vecs[i].e_iv) &&
           (bus.o_Data_Valid === vecs[i].e_dv) && (bus.o_Stall_Fetch === vecs[i].e_sf) &&
           (bus.o_Stall_Memory === vecs[i].e_sm) && (bus.o_Bus_Error === vecs[i].e_be);
      if (vecs[i].e_mreq)
        ok = ok && (bus.o_Mem_Write === vecs[i].e_mwr) &&
             (bus.o_Mem_Addr === vecs[i].e_maddr) && (bus.o_Mem_WData === vecs[i].e_mwd);
      if (vecs[i].e_iv) ok = ok && (bus.o_Instr_Data === vecs[i].e_id);
      if (vecs[i].e_dv) ok = ok && (bus.o_Data_RData === vecs[i].e_dd);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d: got req=%b wr=%b addr=%h wd=%h iv=%b id=%h dv=%b dd=%h sf=%b sm=%b be=%b; want req=%b wr=%b addr=%h wd=%h iv=%b id=%h dv=%b dd=%h sf=%b sm=%b be=%b",
                 i, bus.o_Mem_Req, bus.o_Mem_Write, bus.o_Mem_Addr, bus.o_Mem_WData,
                 bus.o_Instr_Valid, bus.o_Instr_Data, bus.o_Data_Valid, bus.o_Data_RData,
                 bus.o_Stall_Fetch, bus.o_Stall_Memory, bus.o_Bus_Error,
                 vecs[i].e_mreq, vecs[i].e_mwr, vecs[i].e_maddr, vecs[i].e_mwd, vecs[i].e_iv,
                 vecs[i].e_id, vecs[i].e_dv, vecs[i].e_dd, vecs[i].e_sf, vecs[i].e_sm,
                 vecs[i].e_be);
      end
    end

    // Timeout sequence: count Mem_Req cycles and find the abort Valid within a bound.
    @(posedge clk);
    #1;
    drive(idle);
    bus.i_Instr_Req  = 1'b1;
    bus.i_Instr_Addr = 32'h120;
    seen  = -1;
    mcnt  = 0;
    vdata = 32'hFFFF_FFFF;
    berr  = 1'b0;
    for (int k = 0; k < 20 && seen < 0; k++) begin
      @(negedge clk);
      if (bus.o_Mem_Req) mcnt++;
      if (bus.o_Instr_Valid) begin
        seen  = k;
        vdata = bus.o_Instr_Data;
        berr  = bus.o_Bus_Error;
      end
      @(posedge clk);
      #1;
    end
    bus.i_Instr_Req = 1'b0;

    checks++;
    if (seen != 1 + Tmo) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles want %0d", seen, 1 + Tmo);
    end
    checks++;
    if (mcnt != Tmo) begin
      errors++;
      $display("FAIL tmo_req_cycles: got %0d want %0d", mcnt, Tmo);
    end
    checks++;
    if (vdata !== 32'h0) begin
      errors++;
      $display("FAIL tmo_data: got %h want 00000000", vdata);
    end
    checks++;
    if (berr !== 1'b1) begin
      errors++;
      $display("FAIL tmo_bus_error: got %b want 1", berr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arm_pipelined_mem_arbiter.md
# arm_pipelined_mem_arbiter

Shares one single-ported external memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the pipelined ARM core. Each side gets a request/valid handshake. The block produces stall requests for the hazard unit while an access is outstanding. It also aborts accesses the memory never acknowledges, raising a sticky bus error.

## Interface
- BusWidth, 32, address/data width
- TimeoutCycles, 16, max cycles a granted access waits for i_Mem_Ack before abort (≥2)

- i_CLK  in  1  clock, all state on rising edge
- i_RESET  in  1  synchronous, active-high reset
- i_Instr_Req  in  1  fetch read request, held until o_Instr_Valid
- i_Instr_Addr  in  BusWidth  fetch address (PC)
- o_Instr_Data  out  BusWidth  fetched instruction, valid with o_Instr_Valid
- o_Instr_Valid  out  1  one-cycle completion pulse for fetch
- i_Data_Req  in  1  data access request, held until o_Data_Valid
- i_Data_Write  in  1  1 = store, 0 = load
- i_Data_Addr  in  BusWidth  data address (ALU result, memory stage)
- i_Data_WData  in  BusWidth  store data
- o_Data_RData  out  BusWidth  load data, valid with o_Data_Valid; 0 for stores
- o_Data_Valid  out  1  one-cycle completion pulse for data
- o_Mem_Req  out  1  memory access request
- o_Mem_Write  out  1  memory write strobe qualifier
- o_Mem_Addr  out  BusWidth  memory address
- o_Mem_WData  out  BusWidth  memory write data
- i_Mem_Ack  in  1  access complete; i_Mem_RData valid this cycle for reads
- i_Mem_RData  in  BusWidth  memory read data
- o_Stall_Fetch  out  1  to hazard unit: fetch access pending
- o_Stall_Memory  out  1  to hazard unit: data access pending
- o_Bus_Error  out  1  sticky: an access timed out

## Operation
- States: IDLE, INSTR (fetch access in flight), DATA (data access in flight).
- Eligibility in IDLE: a requester is eligible if its Req = 1 and its Valid is not high this cycle. The Valid-high mask lets the pipeline present its next request.
- Grant in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant the one not served last. last_served resets to INSTR, so data wins the first conflict.
- On grant:
  - Latch Addr, Write and WData into o_Mem_* (fetch: Write = 0, WData = 0).
  - Go to INSTR or DATA and clear the wait counter.
- In INSTR/DATA:
  - o_Mem_Req = 1 and o_Mem_* held stable.
  - Wait counter increments each cycle without ack.
- On i_Mem_Ack in INSTR/DATA:
  - Register i_Mem_RData into the served side's data output (0 for a store).
  - Pulse that side's Valid next cycle, update last_served, return to IDLE.
- Timeout: the counter reaches TimeoutCycles−1 without ack.
  - Abort: return to IDLE, pulse the served Valid with data 0, set o_Bus_Error.
  - o_Bus_Error clears only on reset.
- i_Mem_Ack in IDLE is ignored.
- o_Stall_Fetch = i_Instr_Req & ~o_Instr_Valid. o_Stall_Memory = i_Data_Req & ~o_Data_Valid. Both are combinational.
- Requests must not change address/data while held. The arbiter latches at grant, so later changes are not observed.

## Timing
- Reset, first edge with i_RESET = 1:
  - state IDLE, counter 0, last_served INSTR.
  - All registered outputs 0: o_Mem_Req, o_Mem_Write, o_Mem_Addr, o_Mem_WData, both Valids, o_Instr_Data, o_Data_RData, o_Bus_Error.
- Reset mid-access drops the access immediately: no Valid pulse, o_Mem_Req = 0 next cycle.
- Request seen in IDLE at cycle t → o_Mem_Req = 1 from t+1.
- Ack at cycle a → Valid and data at a+1; state IDLE at a+1.
- Minimum latency: req at t, ack at t+1, Valid at t+2 (2 cycles).
- Back-to-back: the other requester, already pending, is granted in the Valid cycle a+1; o_Mem_Req drops for exactly one cycle (a+1) between accesses.
- Timeout: with no ack, the abort Valid is at t+1+TimeoutCycles; o_Mem_Req is high for TimeoutCycles cycles.
- Valid pulses are exactly one cycle wide. Both Valids are never high in the same cycle.

## Test plan
- Fetch only, ack at the first Mem_Req cycle, addr 0x100, RData 0xE3A01005:
  - o_Mem_Req high one cycle.
  - o_Instr_Valid = 1 with 0xE3A01005 two cycles after the request.
  - o_Stall_Fetch high for those two cycles.
- Both request from reset: load addr 0x200, fetch addr 0x104, ack 1 cycle after each Mem_Req:
  - Data is served first.
  - Fetch is granted in the o_Data_Valid cycle; o_Mem_Addr = 0x104 next.
  - Next conflict grants fetch first (round-robin).
- Store addr 0x300, WData 0xDEADBEEF, ack after 3 cycles:
  - o_Mem_Write = 1, o_Mem_WData = 0xDEADBEEF stable for 3 cycles.
  - o_Data_Valid pulse with o_Data_RData = 0.
- Timeout with TimeoutCycles = 4, fetch with no ack:
  - o_Mem_Req high 4 cycles.
  - o_Instr_Valid with data 0.
  - o_Bus_Error = 1 and stays high across later successful accesses until reset.
- i_RESET asserted on the second cycle of an in-flight data access:
  - Next cycle all outputs 0, state IDLE, no Valid pulse.
  - A request re-issued after reset completes normally.
